// File: rtl/flicker_pkg.sv
// Shared constants and helpers for the GPIO flicker bridge.
package flicker_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // Pointer/level width: one extra bit distinguishes full from empty.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/flicker_fifo.sv
// One direction of the bridge: toggle-handshake capture -> circular buffer -> toggle-handshake present.
// Capture acks in the sampling cycle; presentation is one registered cycle later; full FIFO withholds the ack.
module flicker_fifo
  import flicker_pkg::*;
#(
  parameter int pDATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int pDEPTH      = 4
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_clear,
  input  logic [pDATA_WIDTH-1:0]             i_wr_data,
  input  logic                               i_wr_flicker,
  output logic                               o_wr_ack,
  output logic [pDATA_WIDTH-1:0]             o_rd_data,
  output logic                               o_rd_flicker,
  input  logic                               i_rd_ack,
  output logic [level_width(pDEPTH)-1:0]     o_level
);

  localparam int LW = level_width(pDEPTH);
  localparam int AW = LW - 1;

  logic [pDATA_WIDTH-1:0] r_mem [pDEPTH];
  logic [LW-1:0]          r_wptr;
  logic [LW-1:0]          r_rptr;
  logic [LW-1:0]          r_level;
  logic                   r_wr_ack;
  logic                   r_rd_flicker;
  logic                   r_presented;
  logic [pDATA_WIDTH-1:0] r_rd_data;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // Pop first so a full FIFO can accept a word in the same cycle it frees a slot.
  assign w_pop  = (r_rd_flicker == i_rd_ack) && !w_empty && !r_presented && !i_clear;
  assign w_push = (i_wr_flicker != r_wr_ack) && (!w_full || w_pop) && !i_clear;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_level      <= '0;
      r_wr_ack     <= 1'b0;
      r_rd_flicker <= 1'b0;
      r_rd_data    <= '0;
      r_presented  <= 1'b0;
    end else if (i_clear) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_presented <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr   <= r_wptr + 1'b1;
        r_wr_ack <= i_wr_flicker;
      end
      if (w_pop) begin
        r_rptr       <= r_rptr + 1'b1;
        r_rd_data    <= r_mem[r_rptr[AW-1:0]];
        r_rd_flicker <= ~r_rd_flicker;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      r_presented <= w_pop;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_wr_data;
    end
  end

  assign o_wr_ack     = r_wr_ack;
  assign o_rd_data    = r_rd_data;
  assign o_rd_flicker = r_rd_flicker;
  assign o_level      = r_level;

endmodule

// File: rtl/gpio_flicker_bridge.sv
// Buffered H2P/P2H flicker bridge between the CW305 register block and PULPino GPIO.
// Define FLICKER_SYNC_EN to add 2-flop synchronisers (2 extra cycles) on all incoming flicker/ack lines.
module gpio_flicker_bridge
  import flicker_pkg::*;
#(
  parameter int pDATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int pDEPTH      = 4
) (
  input  logic                           crypto_clk,
  input  logic                           reset_i,
  input  logic                           I_clear,
  input  logic [pDATA_WIDTH-1:0]         I_host_wr_data,
  input  logic                           I_host_wr_flicker,
  output logic                           O_host_wr_ack,
  output logic [pDATA_WIDTH-1:0]         O_cpu_rd_data,
  output logic                           O_cpu_rd_flicker,
  input  logic                           I_cpu_rd_ack,
  input  logic [pDATA_WIDTH-1:0]         I_cpu_wr_data,
  input  logic                           I_cpu_wr_flicker,
  output logic                           O_cpu_wr_ack,
  output logic [pDATA_WIDTH-1:0]         O_host_rd_data,
  output logic                           O_host_rd_flicker,
  input  logic                           I_host_rd_ack,
  output logic [level_width(pDEPTH)-1:0] O_h2p_level,
  output logic [level_width(pDEPTH)-1:0] O_p2h_level
);

  logic w_host_wr_flicker;
  logic w_host_rd_ack;
  logic w_cpu_wr_flicker;
  logic w_cpu_rd_ack;

`ifdef FLICKER_SYNC_EN
  logic [1:0] r_host_wr_flicker_sync;
  logic [1:0] r_host_rd_ack_sync;
  logic [1:0] r_cpu_wr_flicker_sync;
  logic [1:0] r_cpu_rd_ack_sync;

  always_ff @(posedge crypto_clk) begin
    if (reset_i) begin
      r_host_wr_flicker_sync <= '0;
      r_host_rd_ack_sync     <= '0;
      r_cpu_wr_flicker_sync  <= '0;
      r_cpu_rd_ack_sync      <= '0;
    end else begin
      r_host_wr_flicker_sync <= {r_host_wr_flicker_sync[0], I_host_wr_flicker};
      r_host_rd_ack_sync     <= {r_host_rd_ack_sync[0], I_host_rd_ack};
      r_cpu_wr_flicker_sync  <= {r_cpu_wr_flicker_sync[0], I_cpu_wr_flicker};
      r_cpu_rd_ack_sync      <= {r_cpu_rd_ack_sync[0], I_cpu_rd_ack};
    end
  end

  assign w_host_wr_flicker = r_host_wr_flicker_sync[1];
  assign w_host_rd_ack     = r_host_rd_ack_sync[1];
  assign w_cpu_wr_flicker  = r_cpu_wr_flicker_sync[1];
  assign w_cpu_rd_ack      = r_cpu_rd_ack_sync[1];
`else
  assign w_host_wr_flicker = I_host_wr_flicker;
  assign w_host_rd_ack     = I_host_rd_ack;
  assign w_cpu_wr_flicker  = I_cpu_wr_flicker;
  assign w_cpu_rd_ack      = I_cpu_rd_ack;
`endif

  flicker_fifo #(
    .pDATA_WIDTH (pDATA_WIDTH),
    .pDEPTH      (pDEPTH)
  ) u_h2p (
    .i_clk        (crypto_clk),
    .i_rst        (reset_i),
    .i_clear      (I_clear),
    .i_wr_data    (I_host_wr_data),
    .i_wr_flicker (w_host_wr_flicker),
    .o_wr_ack     (O_host_wr_ack),
    .o_rd_data    (O_cpu_rd_data),
    .o_rd_flicker (O_cpu_rd_flicker),
    .i_rd_ack     (w_cpu_rd_ack),
    .o_level      (O_h2p_level)
  );

  flicker_fifo #(
    .pDATA_WIDTH (pDATA_WIDTH),
    .pDEPTH      (pDEPTH)
  ) u_p2h (
    .i_clk        (crypto_clk),
    .i_rst        (reset_i),
    .i_clear      (I_clear),
    .i_wr_data    (I_cpu_wr_data),
    .i_wr_flicker (w_cpu_wr_flicker),
    .o_wr_ack     (O_cpu_wr_ack),
    .o_rd_data    (O_host_rd_data),
    .o_rd_flicker (O_host_rd_flicker),
    .i_rd_ack     (w_host_rd_ack),
    .o_level      (O_p2h_level)
  );

endmodule

// File: tb/tb_gpio_flicker_bridge.sv
// Bench for gpio_flicker_bridge: queue-level reference model checked every cycle plus directed literal checks.
module tb_gpio_flicker_bridge;

  localparam int DW = 8;
  localparam int D  = 4;
  localparam int LW = 3;
`ifdef FLICKER_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic          crypto_clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          I_clear = 1'b0;
  logic [DW-1:0] I_host_wr_data = '0;
  logic          I_host_wr_flicker = 1'b0;
  logic          O_host_wr_ack;
  logic [DW-1:0] O_cpu_rd_data;
  logic          O_cpu_rd_flicker;
  logic          I_cpu_rd_ack = 1'b0;
  logic [DW-1:0] I_cpu_wr_data = '0;
  logic          I_cpu_wr_flicker = 1'b0;
  logic          O_cpu_wr_ack;
  logic [DW-1:0] O_host_rd_data;
  logic          O_host_rd_flicker;
  logic          I_host_rd_ack = 1'b0;
  logic [LW-1:0] O_h2p_level;
  logic [LW-1:0] O_p2h_level;

  int n_vec  = 0;
  int n_miss = 0;

  gpio_flicker_bridge #(.pDATA_WIDTH(DW), .pDEPTH(D)) dut (
    .crypto_clk        (crypto_clk),
    .reset_i           (reset_i),
    .I_clear           (I_clear),
    .I_host_wr_data    (I_host_wr_data),
    .I_host_wr_flicker (I_host_wr_flicker),
    .O_host_wr_ack     (O_host_wr_ack),
    .O_cpu_rd_data     (O_cpu_rd_data),
    .O_cpu_rd_flicker  (O_cpu_rd_flicker),
    .I_cpu_rd_ack      (I_cpu_rd_ack),
    .I_cpu_wr_data     (I_cpu_wr_data),
    .I_cpu_wr_flicker  (I_cpu_wr_flicker),
    .O_cpu_wr_ack      (O_cpu_wr_ack),
    .O_host_rd_data    (O_host_rd_data),
    .O_host_rd_flicker (O_host_rd_flicker),
    .I_host_rd_ack     (I_host_rd_ack),
    .O_h2p_level       (O_h2p_level),
    .O_p2h_level       (O_p2h_level)
  );

  initial forever #5 crypto_clk = ~crypto_clk;

  // Reference model: channel 0 = H2P, channel 1 = P2H; FIFO contents kept as an ordered list.
  logic [DW-1:0] m_buf [2][D];
  int            m_cnt [2];
  logic          m_ack [2];
  logic          m_rflk [2];
  logic          m_just [2];
  logic [DW-1:0] m_rdat [2];
  logic          m_p1f [2];
  logic          m_p2f [2];
  logic          m_p1a [2];
  logic          m_p2a [2];

  always @(posedge crypto_clk) begin
    logic          raw_f [2];
    logic          raw_a [2];
    logic [DW-1:0] raw_d [2];
    logic          f, a, pop, push;
    raw_f[0] = I_host_wr_flicker; raw_a[0] = I_cpu_rd_ack;  raw_d[0] = I_host_wr_data;
    raw_f[1] = I_cpu_wr_flicker;  raw_a[1] = I_host_rd_ack; raw_d[1] = I_cpu_wr_data;
    for (int c = 0; c < 2; c++) begin
`ifdef FLICKER_SYNC_EN
      f = m_p2f[c]; a = m_p2a[c];
      m_p2f[c] = m_p1f[c]; m_p1f[c] = raw_f[c];
      m_p2a[c] = m_p1a[c]; m_p1a[c] = raw_a[c];
`else
      f = raw_f[c]; a = raw_a[c];
`endif
      if (reset_i) begin
        m_cnt[c] = 0; m_ack[c] = 1'b0; m_rflk[c] = 1'b0; m_rdat[c] = '0; m_just[c] = 1'b0;
        m_p1f[c] = 1'b0; m_p2f[c] = 1'b0; m_p1a[c] = 1'b0; m_p2a[c] = 1'b0;
      end else begin
        pop  = (m_rflk[c] == a) && (m_cnt[c] > 0) && !m_just[c] && !I_clear;
        push = (f != m_ack[c]) && ((m_cnt[c] < D) || pop) && !I_clear;
        if (I_clear) begin
          m_cnt[c] = 0;
        end else begin
          if (pop) begin
            m_rdat[c] = m_buf[c][0];
            for (int k = 0; k < D - 1; k++) m_buf[c][k] = m_buf[c][k+1];
            m_cnt[c]  = m_cnt[c] - 1;
            m_rflk[c] = !m_rflk[c];
          end
          if (push) begin
            m_buf[c][m_cnt[c]] = raw_d[c];
            m_cnt[c] = m_cnt[c] + 1;
            m_ack[c] = f;
          end
        end
        m_just[c] = pop;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge crypto_clk);
    chk("h2p_wr_ack",   O_host_wr_ack,     m_ack[0]);
    chk("h2p_rd_data",  O_cpu_rd_data,     m_rdat[0]);
    chk("h2p_rd_flk",   O_cpu_rd_flicker,  m_rflk[0]);
    chk("h2p_level",    O_h2p_level,       m_cnt[0]);
    chk("p2h_wr_ack",   O_cpu_wr_ack,      m_ack[1]);
    chk("p2h_rd_data",  O_host_rd_data,    m_rdat[1]);
    chk("p2h_rd_flk",   O_host_rd_flicker, m_rflk[1]);
    chk("p2h_level",    O_p2h_level,       m_cnt[1]);
  endtask

  task automatic host_wait_ack();
    for (int k = 0; k < 40 && O_host_wr_ack != I_host_wr_flicker; k++) tick();
    chk("host_ack_wait", O_host_wr_ack, I_host_wr_flicker);
  endtask

  task automatic host_send(input logic [DW-1:0] v);
    host_wait_ack();
    I_host_wr_data = v;
    I_host_wr_flicker = !I_host_wr_flicker;
    tick();
  endtask

  task automatic cpu_send(input logic [DW-1:0] v);
    for (int k = 0; k < 40 && O_cpu_wr_ack != I_cpu_wr_flicker; k++) tick();
    chk("cpu_ack_wait", O_cpu_wr_ack, I_cpu_wr_flicker);
    I_cpu_wr_data = v;
    I_cpu_wr_flicker = !I_cpu_wr_flicker;
    tick();
  endtask

  task automatic cpu_take(input logic [DW-1:0] v);
    I_cpu_rd_ack = O_cpu_rd_flicker;
    tick();
    for (int k = 0; k < 40 && O_cpu_rd_flicker == I_cpu_rd_ack; k++) tick();
    chk("cpu_take_wait", O_cpu_rd_flicker, !I_cpu_rd_ack);
    chk("cpu_take_data", O_cpu_rd_data, v);
  endtask

  task automatic host_take(input logic [DW-1:0] v);
    for (int k = 0; k < 40 && O_host_rd_flicker == I_host_rd_ack; k++) tick();
    chk("host_take_wait", O_host_rd_flicker, !I_host_rd_ack);
    chk("host_take_data", O_host_rd_data, v);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_h2p_level", O_h2p_level, 0);
    chk("rst_cpu_rd_flk", O_cpu_rd_flicker, 0);
    chk("rst_host_wr_ack", O_host_wr_ack, 0);
    reset_i = 1'b0;
    tick();

    // Single word
    I_host_wr_data = 8'hA5;
    I_host_wr_flicker = 1'b1;
    repeat (1 + SL) tick();
    chk("single_ack", O_host_wr_ack, 1);
    chk("single_level_push", O_h2p_level, 1);
    tick();
    chk("single_data", O_cpu_rd_data, 8'hA5);
    chk("single_flk", O_cpu_rd_flicker, 1);
    chk("single_level_pop", O_h2p_level, 0);
    I_cpu_rd_ack = 1'b1;

    // Burst to full with the CPU stalled
    for (int v = 1; v <= 6; v++) host_send(DW'(v));
    repeat (6) tick();
    chk("full_level", O_h2p_level, 4);
    chk("full_ack_withheld", O_host_wr_ack, 0);
    chk("full_head", O_cpu_rd_data, 8'h01);

    // CPU ack lands while the 0x06 request is pending at full
    I_cpu_rd_ack = 1'b0;
    repeat (1 + SL) tick();
    chk("simul_level", O_h2p_level, 4);
    chk("simul_ack", O_host_wr_ack, 1);
    chk("simul_data", O_cpu_rd_data, 8'h02);
    for (int v = 3; v <= 6; v++) cpu_take(DW'(v));
    chk("drain_level", O_h2p_level, 0);

    // Clear colliding with a capture
    host_send(8'h11);
    host_send(8'h22);
    host_send(8'h33);
    host_wait_ack();
    chk("pre_clear_level", O_h2p_level, 3);
    I_host_wr_data = 8'h44;
    I_host_wr_flicker = !I_host_wr_flicker;
    I_clear = 1'b1;
    tick();
    I_clear = 1'b0;
    chk("clear_level", O_h2p_level, 0);
    chk("clear_rd_data", O_cpu_rd_data, 8'h06);
    chk("clear_ack_held", O_host_wr_ack, !I_host_wr_flicker);
    host_wait_ack();
    chk("clear_recapture_level", O_h2p_level, 1);
    cpu_take(8'h44);

    // P2H back-to-back
    cpu_send(8'h3C);
    cpu_send(8'hC3);
    host_take(8'h3C);
    repeat (4) tick();
    chk("p2h_hold_data", O_host_rd_data, 8'h3C);
    chk("p2h_hold_level", O_p2h_level, 1);
    I_host_rd_ack = O_host_rd_flicker;
    tick();
    host_take(8'hC3);
    I_host_rd_ack = O_host_rd_flicker;

    // Reset mid-burst
    host_send(8'h55);
    host_send(8'h66);
    host_wait_ack();
    chk("pre_rst_level", O_h2p_level, 2);
    reset_i = 1'b1;
    I_host_wr_flicker = 1'b0; I_cpu_rd_ack = 1'b0;
    I_cpu_wr_flicker = 1'b0;  I_host_rd_ack = 1'b0;
    tick();
    reset_i = 1'b0;
    chk("rst_mid_level", O_h2p_level, 0);
    chk("rst_mid_ack", O_host_wr_ack, 0);
    chk("rst_mid_flk", O_cpu_rd_flicker, 0);
    chk("rst_mid_data", O_cpu_rd_data, 0);
    host_send(8'h5A);
    host_wait_ack();
    for (int k = 0; k < 40 && O_cpu_rd_flicker == I_cpu_rd_ack; k++) tick();
    chk("post_rst_flk", O_cpu_rd_flicker, 1);
    chk("post_rst_data", O_cpu_rd_data, 8'h5A);
    I_cpu_rd_ack = O_cpu_rd_flicker;

    // Randomised traffic, alternating fast and slow consumers
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int lim;
      lim = ((cyc / 400) % 2 == 1) ? 7 : 1;
      tick();
      reset_i = ($urandom_range(0, 599) == 0);
      I_clear = ($urandom_range(0, 79) == 0);
      if (reset_i) begin
        I_host_wr_flicker = 1'b0; I_cpu_rd_ack = 1'b0;
        I_cpu_wr_flicker = 1'b0;  I_host_rd_ack = 1'b0;
      end else begin
        if (I_host_wr_flicker == O_host_wr_ack && $urandom_range(0, 2) != 0) begin
          I_host_wr_data = DW'($urandom);
          I_host_wr_flicker = !I_host_wr_flicker;
        end
        if (I_cpu_wr_flicker == O_cpu_wr_ack && $urandom_range(0, 2) != 0) begin
          I_cpu_wr_data = DW'($urandom);
          I_cpu_wr_flicker = !I_cpu_wr_flicker;
        end
        if (O_cpu_rd_flicker != I_cpu_rd_ack && $urandom_range(0, lim) == 0)
          I_cpu_rd_ack = O_cpu_rd_flicker;
        if (O_host_rd_flicker != I_host_rd_ack && $urandom_range(0, lim) == 0)
          I_host_rd_ack = O_host_rd_flicker;
      end
    end
    reset_i = 1'b0;
    I_clear = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
